// File: rtl/rr_sel_arbiter_pkg.sv
// Shared constants for the round-robin mux-select arbiter.
package rr_sel_arbiter_pkg;

  localparam int NUM_SRC = 4;
  localparam int SEL_W   = 2;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  // One-hot decode of a source index, used for the grant vector.
  function automatic logic [NUM_SRC-1:0] onehot_sel(input logic [SEL_W-1:0] s);
    logic [NUM_SRC-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_sel_arbiter_pick.sv
// Rotating-priority pick: first set req bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
module rr_pick4
  import rr_sel_arbiter_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   idx,
  output logic               found
);

  logic [SEL_W-1:0] cand;

  // Scan from the farthest offset down so the offset closest to ptr wins last.
  always_comb begin
    idx   = ptr;
    found = 1'b0;
    cand  = ptr;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter producing a registered select for a downstream 4:1 mux,
// with bounded bursts per grant and zero-bubble handover between sources.
module rr_sel_arbiter
  import rr_sel_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_SRC-1:0]   req,
  input  logic                 out_ready,
  output logic [SEL_W-1:0]     sel,
  output logic [NUM_SRC-1:0]   grant,
  output logic                 out_valid
);

  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

  logic                 state_q,    state_d;
  logic [SEL_W-1:0]     sel_q,      sel_d;
  logic [NUM_SRC-1:0]   grant_q,    grant_d;
  logic [SEL_W-1:0]     ptr_q,      ptr_d;
  logic [3:0]           beat_cnt_q, beat_cnt_d;

  logic                 xfer;
  logic                 rel;
  logic [SEL_W-1:0]     pick_ptr;
  logic [SEL_W-1:0]     pick_idx;
  logic                 pick_found;

  assign out_valid = (state_q == ST_BUSY) && req[sel_q];
  assign xfer      = out_valid && out_ready;

  // A withdrawn request (req[sel] low) releases even while stalled; no beat counts then.
  assign rel = (state_q == ST_BUSY) &&
               ((xfer && (beat_cnt_q == LAST_BEAT)) || !req[sel_q]);

  // On release the pick already uses the advanced pointer so handover has no idle cycle.
  assign pick_ptr = rel ? (sel_q + 2'd1) : ptr_q;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Next-state logic: arbitrate from IDLE, count beats, release and re-arbitrate in BUSY.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    beat_cnt_d = beat_cnt_q;
    if (state_q == ST_IDLE) begin
      if (pick_found) begin
        state_d    = ST_BUSY;
        sel_d      = pick_idx;
        grant_d    = onehot_sel(pick_idx);
        beat_cnt_d = 4'd0;
      end
    end else if (rel) begin
      ptr_d      = pick_ptr;
      beat_cnt_d = 4'd0;
      if (pick_found) begin
        sel_d   = pick_idx;
        grant_d = onehot_sel(pick_idx);
      end else begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    end else if (xfer) begin
      beat_cnt_d = beat_cnt_q + 4'd1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      grant_q    <= '0;
      ptr_q      <= '0;
      beat_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign sel   = sel_q;
  assign grant = grant_q;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Scoreboard bench for rr_sel_arbiter with MAX_BURST = 4, 1 and 2 instances.
module tb_rr_sel_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       out_ready;

  logic [1:0] sel4, sel1, sel2;
  logic [3:0] grant4, grant1, grant2;
  logic       vld4, vld1, vld2;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] grant;
    logic       vld;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  int n_cmp;
  int n_bad;
  int which;

  logic [1:0] o_sel;
  logic [3:0] o_grant;
  logic       o_vld;

  rr_sel_arbiter #(.MAX_BURST(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
    .sel(sel4), .grant(grant4), .out_valid(vld4));

  rr_sel_arbiter #(.MAX_BURST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
    .sel(sel1), .grant(grant1), .out_valid(vld1));

  rr_sel_arbiter #(.MAX_BURST(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
    .sel(sel2), .grant(grant2), .out_valid(vld2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    o_sel   = sel4;
    o_grant = grant4;
    o_vld   = vld4;
    case (which)
      1: begin o_sel = sel1; o_grant = grant1; o_vld = vld1; end
      2: begin o_sel = sel2; o_grant = grant2; o_vld = vld2; end
      default: ;
    endcase
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = 4'b0000;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic push_exp(input logic [1:0] s, input logic [3:0] g, input logic v, input int n);
    exp_t x;
    x.sel   = s;
    x.grant = g;
    x.vld   = v;
    for (int i = 0; i < n; i++) exp_q.push_back(x);
  endtask

  task automatic test_reset();
    which     = 4;
    rst_n     = 1'b1;
    req       = 4'b1111;
    out_ready = 1'b1;
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({sel4, grant4, vld4, sel1, grant1, vld1, sel2, grant2, vld2} !== 21'b0) begin
      n_bad++;
      $display("FAIL reset_async: got sel4=%0d g4=%b v4=%b sel1=%0d g1=%b v1=%b sel2=%0d g2=%b v2=%b, want all zero",
               sel4, grant4, vld4, sel1, grant1, vld1, sel2, grant2, vld2);
    end
    n_cmp++;
    if ({dut4.ptr_q, dut4.beat_cnt_q} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_ptr_beat: got ptr=%0d beat=%0d, want 0 0", dut4.ptr_q, dut4.beat_cnt_q);
    end
    do_reset();
  endtask

  task automatic test_burst4();
    which = 4;
    do_reset();
    req       = 4'b0101;
    out_ready = 1'b1;
    push_exp(2'd0, 4'b0001, 1'b1, 4);
    push_exp(2'd2, 4'b0100, 1'b1, 4);
    push_exp(2'd0, 4'b0001, 1'b1, 1);
    for (int k = 0; k < 9; k++) begin
      step();
      e = exp_q.pop_front();
      n_cmp++;
      if ({o_sel, o_grant, o_vld} !== e) begin
        n_bad++;
        $display("FAIL burst4 cyc%0d: got sel=%0d grant=%b vld=%b, want sel=%0d grant=%b vld=%b",
                 k, o_sel, o_grant, o_vld, e.sel, e.grant, e.vld);
      end
    end
    req = 4'b0000;
    push_exp(2'd0, 4'b0000, 1'b0, 2);
    for (int k = 0; k < 2; k++) begin
      step();
      e = exp_q.pop_front();
      n_cmp++;
      if ({o_sel, o_grant, o_vld} !== e) begin
        n_bad++;
        $display("FAIL idle_hold cyc%0d: got sel=%0d grant=%b vld=%b, want sel=%0d grant=%b vld=%b",
                 k, o_sel, o_grant, o_vld, e.sel, e.grant, e.vld);
      end
    end
  endtask

  task automatic test_rr_burst1();
    which = 1;
    do_reset();
    req       = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      logic [1:0] s;
      s = 2'(k);
      push_exp(s, 4'b0001 << s, 1'b1, 1);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      e = exp_q.pop_front();
      n_cmp++;
      if ({o_sel, o_grant, o_vld} !== e) begin
        n_bad++;
        $display("FAIL rr_burst1 cyc%0d: got sel=%0d grant=%b vld=%b, want sel=%0d grant=%b vld=%b",
                 k, o_sel, o_grant, o_vld, e.sel, e.grant, e.vld);
      end
    end
  endtask

  task automatic test_single_src();
    which = 2;
    do_reset();
    req       = 4'b0100;
    out_ready = 1'b1;
    push_exp(2'd2, 4'b0100, 1'b1, 6);
    for (int k = 0; k < 6; k++) begin
      step();
      e = exp_q.pop_front();
      n_cmp++;
      if ({o_sel, o_grant, o_vld} !== e || dut2.beat_cnt_q !== 4'(k % 2)) begin
        n_bad++;
        $display("FAIL single_src cyc%0d: got sel=%0d grant=%b vld=%b beat=%0d, want sel=%0d grant=%b vld=%b beat=%0d",
                 k, o_sel, o_grant, o_vld, dut2.beat_cnt_q, e.sel, e.grant, e.vld, k % 2);
      end
    end
  endtask

  task automatic test_stall();
    which = 4;
    do_reset();
    req       = 4'b1000;
    out_ready = 1'b0;
    push_exp(2'd3, 4'b1000, 1'b1, 6);
    for (int k = 0; k < 6; k++) begin
      step();
      e = exp_q.pop_front();
      n_cmp++;
      if ({o_sel, o_grant, o_vld} !== e || dut4.beat_cnt_q !== 4'd0) begin
        n_bad++;
        $display("FAIL stall cyc%0d: got sel=%0d grant=%b vld=%b beat=%0d, want sel=%0d grant=%b vld=%b beat=0",
                 k, o_sel, o_grant, o_vld, dut4.beat_cnt_q, e.sel, e.grant, e.vld);
      end
    end
    out_ready = 1'b1;
    push_exp(2'd3, 4'b1000, 1'b1, 1);
    step();
    e = exp_q.pop_front();
    n_cmp++;
    if ({o_sel, o_grant, o_vld} !== e || dut4.beat_cnt_q !== 4'd1) begin
      n_bad++;
      $display("FAIL stall_beat: got sel=%0d grant=%b vld=%b beat=%0d, want sel=%0d grant=%b vld=%b beat=1",
               o_sel, o_grant, o_vld, dut4.beat_cnt_q, e.sel, e.grant, e.vld);
    end
    req = 4'b0011;
    push_exp(2'd0, 4'b0001, 1'b1, 1);
    step();
    e = exp_q.pop_front();
    n_cmp++;
    if ({o_sel, o_grant, o_vld} !== e || dut4.ptr_q !== 2'd0 || dut4.beat_cnt_q !== 4'd0) begin
      n_bad++;
      $display("FAIL stall_wrap: got sel=%0d grant=%b vld=%b ptr=%0d beat=%0d, want sel=%0d grant=%b vld=%b ptr=0 beat=0",
               o_sel, o_grant, o_vld, dut4.ptr_q, dut4.beat_cnt_q, e.sel, e.grant, e.vld);
    end
  endtask

  task automatic test_reset_mid();
    which = 4;
    do_reset();
    req       = 4'b0010;
    out_ready = 1'b1;
    repeat (3) step();
    n_cmp++;
    if (sel4 !== 2'd1 || dut4.beat_cnt_q !== 4'd2) begin
      n_bad++;
      $display("FAIL mid_pre: got sel=%0d beat=%0d, want sel=1 beat=2", sel4, dut4.beat_cnt_q);
    end
    #2;
    rst_n = 1'b0;
    #1;
    push_exp(2'd0, 4'b0000, 1'b0, 1);
    e = exp_q.pop_front();
    n_cmp++;
    if ({o_sel, o_grant, o_vld} !== e) begin
      n_bad++;
      $display("FAIL mid_reset: got sel=%0d grant=%b vld=%b, want sel=%0d grant=%b vld=%b",
               o_sel, o_grant, o_vld, e.sel, e.grant, e.vld);
    end
    step();
    rst_n = 1'b1;
    push_exp(2'd1, 4'b0010, 1'b1, 1);
    step();
    e = exp_q.pop_front();
    n_cmp++;
    if ({o_sel, o_grant, o_vld} !== e || dut4.beat_cnt_q !== 4'd0) begin
      n_bad++;
      $display("FAIL mid_regrant: got sel=%0d grant=%b vld=%b beat=%0d, want sel=%0d grant=%b vld=%b beat=0",
               o_sel, o_grant, o_vld, dut4.beat_cnt_q, e.sel, e.grant, e.vld);
    end
  endtask

  task automatic test_withdraw();
    which = 4;
    do_reset();
    req       = 4'b0001;
    out_ready = 1'b0;
    push_exp(2'd0, 4'b0001, 1'b1, 1);
    push_exp(2'd3, 4'b1000, 1'b1, 1);
    step();
    e = exp_q.pop_front();
    n_cmp++;
    if ({o_sel, o_grant, o_vld} !== e) begin
      n_bad++;
      $display("FAIL withdraw_pre: got sel=%0d grant=%b vld=%b, want sel=%0d grant=%b vld=%b",
               o_sel, o_grant, o_vld, e.sel, e.grant, e.vld);
    end
    req = 4'b1000;
    step();
    e = exp_q.pop_front();
    n_cmp++;
    if ({o_sel, o_grant, o_vld} !== e || dut4.beat_cnt_q !== 4'd0) begin
      n_bad++;
      $display("FAIL withdraw: got sel=%0d grant=%b vld=%b beat=%0d, want sel=%0d grant=%b vld=%b beat=0",
               o_sel, o_grant, o_vld, dut4.beat_cnt_q, e.sel, e.grant, e.vld);
    end
  endtask

  task automatic test_back_to_back();
    which = 4;
    do_reset();
    req       = 4'b0001;
    out_ready = 1'b1;
    push_exp(2'd0, 4'b0001, 1'b1, 4);
    for (int k = 0; k < 4; k++) begin
      step();
      e = exp_q.pop_front();
      n_cmp++;
      if ({o_sel, o_grant, o_vld} !== e) begin
        n_bad++;
        $display("FAIL b2b cyc%0d: got sel=%0d grant=%b vld=%b, want sel=%0d grant=%b vld=%b",
                 k, o_sel, o_grant, o_vld, e.sel, e.grant, e.vld);
      end
    end
    req = 4'b0011;
    push_exp(2'd1, 4'b0010, 1'b1, 1);
    step();
    e = exp_q.pop_front();
    n_cmp++;
    if ({o_sel, o_grant, o_vld} !== e || dut4.ptr_q !== 2'd1) begin
      n_bad++;
      $display("FAIL b2b_handover: got sel=%0d grant=%b vld=%b ptr=%0d, want sel=%0d grant=%b vld=%b ptr=1",
               o_sel, o_grant, o_vld, dut4.ptr_q, e.sel, e.grant, e.vld);
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    which     = 4;
    rst_n     = 1'b0;
    req       = 4'b0000;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_burst4();
    test_rr_burst1();
    test_single_src();
    test_stall();
    test_reset_mid();
    test_withdraw();
    test_back_to_back();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_sel_arbiter.md
RR_SEL_ARBITER -- requirements
Module: rr_sel_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 4, sets the maximum beats transferred per grant before forced rotation; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  4  per-source "data available" level; bit i corresponds to 4:1 mux data input i (0=A, 1=B, 2=C, 3=D).
REQ-005 out_ready  input  1  downstream consumer accepts the current mux output this cycle.
REQ-006 sel  output  2  registered select driving the downstream 4:1 mux select input.
REQ-007 grant  output  4  registered one-hot grant; grant[i] informs source i that its data is being presented.
REQ-008 out_valid  output  1  mux output is valid this cycle.

Function
REQ-009 The block SHALL implement two states: IDLE (no grant) and BUSY (one source granted).
REQ-010 In IDLE, grant SHALL be 4'b0000, out_valid SHALL be 0, and sel SHALL hold its last value.
REQ-011 Arbitration SHALL pick the first set req bit, scanning indices ptr, ptr+1, ptr+2, ptr+3 modulo 4; ptr is a 2-bit internal rotation pointer.
REQ-012 In IDLE, when any req bit is set at a rising edge, the block SHALL move to BUSY on that edge, load sel with the picked index, and set grant to one-hot(sel); latency from req high to out_valid high SHALL be 1 cycle.
REQ-013 In BUSY, out_valid SHALL equal req[sel] (combinational from registered sel), and grant SHALL stay one-hot(sel).
REQ-014 A transfer SHALL occur on a rising edge when out_valid=1 and out_ready=1; beat_cnt (4-bit) SHALL then increment.
REQ-015 Release SHALL occur on a rising edge in BUSY when either (a) a transfer occurs and beat_cnt equals MAX_BURST-1, or (b) req[sel]=0.
REQ-016 On release, ptr SHALL become sel+1 (mod 4; 3 wraps to 0), and beat_cnt SHALL clear to 0.
REQ-017 On release, if any req bit is set in that same cycle, the block SHALL arbitrate using the updated ptr and stay in BUSY with the new sel/grant (no idle bubble). If no req bit is set, it SHALL go to IDLE.
REQ-018 When the released source is the only requester, it SHALL be re-granted immediately with beat_cnt=0.
REQ-019 When out_ready=0 with out_valid=1, sel, grant and beat_cnt SHALL hold (stall); no timeout applies.
REQ-020 Sources SHALL hold req high until their beat transfers. A req drop while stalled is treated as a withdrawal: REQ-015(b) applies and no beat is counted.
REQ-021 When MAX_BURST=1, the block SHALL rotate after every transfer (pure per-beat round-robin).
REQ-022 Requests changing in the same cycle as a transfer SHALL be sampled at that edge; a newly raised req takes part in any arbitration on that edge.

Reset
REQ-023 While rst_n=0, the block SHALL immediately hold: state=IDLE, sel=2'b00, grant=4'b0000, ptr=2'b00, beat_cnt=0; out_valid SHALL therefore be 0.
REQ-024 Reset asserted mid-burst SHALL drop grant and out_valid asynchronously; no partial transfer is recorded.
REQ-025 After rst_n deasserts, the first arbitration SHALL start from ptr=0.

Structure
REQ-026 A shared package SHALL hold: NUM_SRC=4, SEL_W=2, and the state encoding (IDLE=1'b0, BUSY=1'b1).
REQ-027 The rotating priority pick SHALL be a combinational sub-module rr_pick4 with inputs req[3:0] and ptr[1:0] and outputs idx[1:0] and found; it is instantiated once.

Verification
REQ-028 Reset then req=4'b0101, out_ready=1, MAX_BURST=4 -> cycle 1: sel=0, grant=0001; after 4 beats: sel=2, grant=0100; after 4 more beats: sel=0.
REQ-029 req=4'b1111, MAX_BURST=1, out_ready=1 -> sel sequence 0,1,2,3,0 on consecutive cycles with out_valid held at 1.
REQ-030 Granted sel=3, out_ready=0 for 5 cycles, then 1 -> sel/grant=1000 stable while stalled; after the beat, ptr wraps to 0 on release.
REQ-031 Only req[2] high, MAX_BURST=2, out_ready=1 -> grant=0100 continuously; beat_cnt cycles 0,1,0,1 with no out_valid gap.
REQ-032 BUSY on sel=1 after 2 beats, rst_n pulsed low for 1 cycle -> grant=0000 and out_valid=0 immediately; with req=4'b0010 after reset, regrant sel=1 with beat_cnt=0.
REQ-033 Granted sel=0 with out_ready=0, req[0] dropped while req[3]=1 -> next edge: sel=3, grant=1000, beat_cnt=0, no beat counted.
